// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : UART transmitter with configurable frame format behind a TX FIFO.
// Rev     : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx,
  output logic                        busy
);

  localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int AW            = $clog2(FIFO_DEPTH);
  localparam int CW            = $clog2(TICKS_PER_BIT) + 1;
  localparam int BW            = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] c_tick_last = CW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] c_data_last = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] c_stop_last = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   c_depth     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;

  state_t               r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_parity;

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_push      = wr_en & ~w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_bit_end   = (r_baud_cnt == c_tick_last);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == c_stop_last);
  // The FIFO is drained from IDLE or straight out of the last stop bit, so frames abut.
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | w_frame_end);

  generate
    if (PARITY == 1) begin : g_parity_odd
      assign w_head_parity = ~^w_head;
    end else if (PARITY == 2) begin : g_parity_even
      assign w_head_parity = ^w_head;
    end else begin : g_parity_none
      assign w_head_parity = 1'b0;
    end
  endgenerate

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= wr_en & w_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (w_pop) begin
      r_state    <= S_START;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= w_head;
      r_parity   <= w_head_parity;
      r_tx       <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state    <= S_DATA;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == c_data_last) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              // tx is registered, so the next bit is taken from ahead of the shift.
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == c_stop_last) begin
              r_state   <= S_IDLE;
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign tx         = r_tx;
  assign busy       = r_busy;

endmodule
`default_nettype wire
